// File: rtl/abstract_cmd_ctrl_pkg.sv
// Shared Debug Module types for the abstract-command sequencer and its decoder.
package abstract_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    CtrlIdle = 2'd0,
    CtrlGo   = 2'd1,
    CtrlExec = 2'd2
  } ctrl_state_e;

  typedef enum logic [7:0] {
    AccessRegister = 8'h00,
    QuickAccess    = 8'h01,
    AccessMemory   = 8'h02
  } cmdtype_e;

  typedef enum logic [2:0] {
    CmdErrNone         = 3'h0,
    CmdErrBusy         = 3'h1,
    CmdErrNotSupported = 3'h2,
    CmdErrException    = 3'h3,
    CmdErrHaltResume   = 3'h4,
    CmdErrBus          = 3'h5,
    CmdErrOther        = 3'h7
  } cmderr_e;

  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        reserved;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } command_t;

  // Largest legal aarsize is one below this value for the given XLEN.
  function automatic logic [2:0] max_aar(int bus_width);
    return (bus_width == 64) ? 3'd4 : 3'd3;
  endfunction

endpackage

// File: rtl/abstract_cmd_ctrl_decode.sv
// Combinational unpack of an abstract command word plus the unsupported-command check.
// Also used by the CSR block for command readback.
module abstract_cmd_decode
  import abstract_cmd_ctrl_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic [31:0] cmd_i,
  output logic [7:0]  cmd_type_o,
  output logic [2:0]  aarsize_o,
  output logic        aarpostincrement_o,
  output logic        postexec_o,
  output logic        transfer_o,
  output logic        write_o,
  output logic [15:0] regno_o,
  output logic        unsupported_o
);

  localparam logic [2:0] MaxAar = max_aar(BusWidth);

  logic unused_reserved;

  assign cmd_type_o         = cmd_i[31:24];
  assign unused_reserved    = cmd_i[23];
  assign aarsize_o          = cmd_i[22:20];
  assign aarpostincrement_o = cmd_i[19];
  assign postexec_o         = cmd_i[18];
  assign transfer_o         = cmd_i[17];
  assign write_o            = cmd_i[16];
  assign regno_o            = cmd_i[15:0];

  // Only GPR/FPR/CSR register access without post-increment is implemented.
  assign unsupported_o = (cmd_type_o != AccessRegister) ||
                         (aarsize_o >= MaxAar) ||
                         aarpostincrement_o ||
                         (transfer_o && (regno_o[15:14] != 2'b00));

endmodule

// File: rtl/abstract_cmd_ctrl.sv
// Debug Module abstract-command sequencer: validates command writes, runs the
// go/going/halted handshake with the park loop, owns abstractcs.busy/cmderr.
// Optional feature macro: ABSTRACT_AUTOEXEC_EN (abstractauto re-issue).
module abstract_cmd_ctrl
  import abstract_cmd_ctrl_pkg::*;
#(
  parameter int BusWidth  = 32,
  parameter int DataCount = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic [2:0]  cmderr_clr_i,
  input  logic        cmderr_clr_valid_i,
  input  logic        dm_access_i,
  input  logic [3:0]  data_idx_i,
  input  logic [3:0]  progbuf_idx_i,
  input  logic        data_access_i,
  input  logic        halted_i,
  input  logic        going_i,
  input  logic        halted_ack_i,
  input  logic        exception_i,
  input  logic [11:0] autoexecdata_i,
  input  logic [15:0] autoexecprogbuf_i,
  output logic [7:0]  cmd_type_o,
  output logic [2:0]  aarsize_o,
  output logic        aarpostincrement_o,
  output logic        postexec_o,
  output logic        transfer_o,
  output logic        write_o,
  output logic [15:0] regno_o,
  output logic        unsupported_command_o,
  output logic        go_o,
  output logic        cmdbusy_o,
  output logic [2:0]  cmderr_o,
  output logic [1:0]  state_o
);

  // Handshake: cmd_valid_i, cmderr_clr_valid_i, dm_access_i, going_i,
  // halted_ack_i and exception_i are single-cycle strobes sampled on every
  // rising clk_i; there is no back-pressure, go_o is a level held until the
  // cycle after going_i.

  ctrl_state_e state_q, state_d;
  command_t    cmd_q, cmd_d;
  logic        unsupported_q, unsupported_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [2:0]  new_err;
  logic        autoexec_q, autoexec_d;
  logic        autoexec_hit;
  logic        issue;
  logic [31:0] issue_cmd;

  logic [7:0]  dec_cmdtype;
  logic [2:0]  dec_aarsize;
  logic        dec_postinc, dec_postexec, dec_transfer, dec_write, dec_unsupported;
  logic [15:0] dec_regno;

  // An autoexec re-issue replays the latched command; a fresh write takes priority.
  assign issue     = (state_q == CtrlIdle) && (cmd_valid_i || autoexec_q);
  assign issue_cmd = cmd_valid_i ? cmd_i : cmd_q;

  abstract_cmd_decode #(
    .BusWidth(BusWidth)
  ) u_decode (
    .cmd_i             (issue_cmd),
    .cmd_type_o        (dec_cmdtype),
    .aarsize_o         (dec_aarsize),
    .aarpostincrement_o(dec_postinc),
    .postexec_o        (dec_postexec),
    .transfer_o        (dec_transfer),
    .write_o           (dec_write),
    .regno_o           (dec_regno),
    .unsupported_o     (dec_unsupported)
  );

`ifdef ABSTRACT_AUTOEXEC_EN
  logic data_hit, progbuf_hit;
  assign data_hit     = data_access_i && (32'(data_idx_i) < 32'(DataCount)) &&
                        autoexecdata_i[data_idx_i];
  assign progbuf_hit  = !data_access_i && autoexecprogbuf_i[progbuf_idx_i];
  assign autoexec_hit = dm_access_i && (data_hit || progbuf_hit);
`else
  logic unused_autoexec;
  assign unused_autoexec = ^{autoexecdata_i, autoexecprogbuf_i, data_idx_i,
                             progbuf_idx_i, data_access_i, DataCount[0]};
  assign autoexec_hit    = 1'b0;
`endif

  assign autoexec_d = autoexec_hit && (state_q == CtrlIdle) && (cmderr_q == CmdErrNone);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    unsupported_d = unsupported_q;
    new_err       = CmdErrNone;
    unique case (state_q)
      CtrlIdle: begin
        if (issue && (cmderr_q == CmdErrNone)) begin
          cmd_d = '{cmdtype: dec_cmdtype, reserved: 1'b0, aarsize: dec_aarsize,
                    aarpostincrement: dec_postinc, postexec: dec_postexec,
                    transfer: dec_transfer, write: dec_write, regno: dec_regno};
          unsupported_d = dec_unsupported;
          if (!halted_i)                     new_err = CmdErrHaltResume;
          else if (dec_unsupported)          new_err = CmdErrNotSupported;
          else if (dec_transfer || dec_postexec) state_d = CtrlGo;
        end
      end
      CtrlGo: begin
        if (exception_i) begin
          new_err = CmdErrException;
          state_d = CtrlIdle;
        end else if (going_i) begin
          state_d = CtrlExec;
        end
      end
      CtrlExec: begin
        if (exception_i) begin
          new_err = CmdErrException;
          state_d = CtrlIdle;
        end else if (halted_ack_i) begin
          state_d = CtrlIdle;
        end
      end
      default: state_d = CtrlIdle;
    endcase
    if ((state_q != CtrlIdle) && (cmd_valid_i || dm_access_i) && (new_err == CmdErrNone)) begin
      new_err = CmdErrBusy;
    end
  end

  // cmderr is sticky: a new error lands only on a clean register and beats a same-cycle clear.
  always_comb begin
    cmderr_d = cmderr_q;
    if (cmderr_clr_valid_i) cmderr_d = cmderr_q & ~cmderr_clr_i;
    if ((new_err != CmdErrNone) && (cmderr_q == CmdErrNone)) cmderr_d = new_err;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= CtrlIdle;
      cmd_q         <= '0;
      unsupported_q <= 1'b0;
      cmderr_q      <= CmdErrNone;
      autoexec_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      unsupported_q <= unsupported_d;
      cmderr_q      <= cmderr_d;
      autoexec_q    <= autoexec_d;
    end
  end

  assign cmd_type_o            = cmd_q.cmdtype;
  assign aarsize_o             = cmd_q.aarsize;
  assign aarpostincrement_o    = cmd_q.aarpostincrement;
  assign postexec_o            = cmd_q.postexec;
  assign transfer_o            = cmd_q.transfer;
  assign write_o               = cmd_q.write;
  assign regno_o               = cmd_q.regno;
  assign unsupported_command_o = unsupported_q;
  assign go_o                  = (state_q == CtrlGo);
  assign cmdbusy_o             = (state_q != CtrlIdle);
  assign cmderr_o              = cmderr_q;
  assign state_o               = state_q;

endmodule
